// File: rtl/sysid_access_arbiter.sv
// sysid_access_arbiter
//
// Sequencer and two-port read arbiter in front of the system-ID slave.
// After reset the block reads the ID word (slave address 1) and the timestamp
// word (slave address 0). It compares both with the expected values and
// reports the result. It then shares the slave between two Avalon-MM read
// requesters: port A (CPU data master) and port B (JTAG/debug master).
//
// Build option:
//   SYSID_VERIFY_EN  defined   : post-reset ID/timestamp check is built and
//                                can be re-run with verify_start_i.
//                    undefined : no check. The arbiter is live straight out of
//                                reset. verify_done_o is tied to 1, and
//                                id_ok_o and id_fail_o are tied to 0.
//
// Parameters:
//   EXPECTED_ID        expected word at slave address 1
//   EXPECTED_TS        expected word at slave address 0
//
// Ports:
//   clock_i            sole clock, rising edge
//   reset_i            synchronous, active-high reset
//   verify_start_i     one-cycle pulse, re-runs the check (only honoured while arbitrating)
//   a_read_i           port A read request, held until accepted
//   a_address_i        port A word select (0 = timestamp, 1 = ID)
//   a_waitrequest_o    port A request not accepted this cycle
//   a_readdatavalid_o  port A read data valid pulse
//   a_readdata_o       port A registered read data
//   b_*                same as a_*, for port B
//   s_address_o        address to the sysid slave
//   s_readdata_i       zero-latency slave read data
//   verify_done_o      a check has completed since the last reset or restart
//   id_ok_o            both words matched
//   id_fail_o          at least one word mismatched

module sysid_access_arbiter #(
    parameter logic [31:0] EXPECTED_ID = 32'd1486075654,
    parameter logic [31:0] EXPECTED_TS = 32'd0
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        verify_start_i,
    input  logic        a_read_i,
    input  logic        a_address_i,
    output logic        a_waitrequest_o,
    output logic        a_readdatavalid_o,
    output logic [31:0] a_readdata_o,
    input  logic        b_read_i,
    input  logic        b_address_i,
    output logic        b_waitrequest_o,
    output logic        b_readdatavalid_o,
    output logic [31:0] b_readdata_o,
    output logic        s_address_o,
    input  logic [31:0] s_readdata_i,
    output logic        verify_done_o,
    output logic        id_ok_o,
    output logic        id_fail_o
);

    // Arbitration is permitted this cycle.
    logic        arb_active;
    // A verify_start_i pulse is being accepted in place of a grant.
    logic        restart;
    // Slave address driven by the check sequence. It is 0 while arbitrating.
    logic        seq_s_address;

    logic        grant_a;
    logic        grant_b;

    // 1 = port B was granted last, so port A wins the next contention.
    logic        last_b_q;
    logic        last_b_d;
    logic        a_valid_q;
    logic        b_valid_q;
    logic [31:0] a_data_q;
    logic [31:0] a_data_d;
    logic [31:0] b_data_q;
    logic [31:0] b_data_d;

`ifdef SYSID_VERIFY_EN

    // state | meaning
    // V_ID  | read ID word (slave address 1) into id_q
    // V_TS  | read timestamp word (slave address 0) into ts_q
    // V_CMP | compare captured words, publish status
    // ARB   | arbitrate ports A/B; verify_start_i restarts the check
    typedef enum logic [1:0] {
        V_ID  = 2'd0,
        V_TS  = 2'd1,
        V_CMP = 2'd2,
        ARB   = 2'd3
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [31:0] id_q;
    logic [31:0] id_d;
    logic [31:0] ts_q;
    logic [31:0] ts_d;
    logic        done_q;
    logic        done_d;
    logic        ok_q;
    logic        ok_d;
    logic        fail_q;
    logic        fail_d;
    logic        words_match;

    assign words_match = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= V_ID;
            id_q    <= 32'd0;
            ts_q    <= 32'd0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        ts_d          = ts_q;
        done_d        = done_q;
        ok_d          = ok_q;
        fail_d        = fail_q;
        arb_active    = 1'b0;
        restart       = 1'b0;
        seq_s_address = 1'b0;
        case (state_q)
            V_ID: begin
                seq_s_address = 1'b1;
                id_d          = s_readdata_i;
                state_d       = V_TS;
            end
            V_TS: begin
                seq_s_address = 1'b0;
                ts_d          = s_readdata_i;
                state_d       = V_CMP;
            end
            V_CMP: begin
                done_d  = 1'b1;
                ok_d    = words_match;
                fail_d  = !words_match;
                state_d = ARB;
            end
            ARB: begin
                // No grant may leak out during a reset cycle; the registered
                // side is reset anyway, but waitrequest is combinational.
                arb_active = !reset_i;
                if (verify_start_i) begin
                    restart = 1'b1;
                    done_d  = 1'b0;
                    ok_d    = 1'b0;
                    fail_d  = 1'b0;
                    state_d = V_ID;
                end
            end
            default: state_d = V_ID;
        endcase
    end

    assign verify_done_o = done_q;
    assign id_ok_o       = ok_q;
    assign id_fail_o     = fail_q;

`else

    assign arb_active    = !reset_i;
    assign restart       = 1'b0;
    assign seq_s_address = 1'b0;

    assign verify_done_o = 1'b1;
    assign id_ok_o       = 1'b0;
    assign id_fail_o     = 1'b0;

    logic unused_no_verify;
    assign unused_no_verify = ^{EXPECTED_ID, EXPECTED_TS, verify_start_i};

`endif

    // A single requester always wins. Under contention the port that was
    // not granted last wins, which gives strict alternation.
    always_comb begin
        grant_a = arb_active && !restart && a_read_i && (!b_read_i || last_b_q);
        grant_b = arb_active && !restart && b_read_i && (!a_read_i || !last_b_q);
    end

    always_comb begin
        s_address_o = seq_s_address;
        if (grant_a) begin
            s_address_o = a_address_i;
        end else if (grant_b) begin
            s_address_o = b_address_i;
        end
    end

    assign a_waitrequest_o = !grant_a;
    assign b_waitrequest_o = !grant_b;

    always_comb begin
        last_b_d = last_b_q;
        a_data_d = a_data_q;
        b_data_d = b_data_q;
        if (grant_a) begin
            last_b_d = 1'b0;
            a_data_d = s_readdata_i;
        end
        if (grant_b) begin
            last_b_d = 1'b1;
            b_data_d = s_readdata_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            last_b_q  <= 1'b1;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_data_q  <= 32'd0;
            b_data_q  <= 32'd0;
        end else begin
            last_b_q  <= last_b_d;
            a_valid_q <= grant_a;
            b_valid_q <= grant_b;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
        end
    end

    assign a_readdatavalid_o = a_valid_q;
    assign b_readdatavalid_o = b_valid_q;
    assign a_readdata_o      = a_data_q;
    assign b_readdata_o      = b_data_q;

endmodule

// File: tb/tb_sysid_access_arbiter.sv
module tb_sysid_access_arbiter;

    localparam logic [31:0] EID = 32'd1486075654;
    localparam logic [31:0] ETS = 32'd0;
`ifdef SYSID_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vstart = 1'b0;
    logic        a_read = 1'b0, a_addr = 1'b0, b_read = 1'b0, b_addr = 1'b0;
    logic        a_wait, a_valid, b_wait, b_valid, s_addr, v_done, v_ok, v_fail;
    logic [31:0] a_data, b_data, s_data;
    logic [31:0] slave_id = EID;
    logic [31:0] slave_ts = ETS;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Slave: zero-latency combinational read of two words.
    assign s_data = s_addr ? slave_id : slave_ts;

    sysid_access_arbiter #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS)) dut (
        .clock_i(clk), .reset_i(rst), .verify_start_i(vstart),
        .a_read_i(a_read), .a_address_i(a_addr), .a_waitrequest_o(a_wait),
        .a_readdatavalid_o(a_valid), .a_readdata_o(a_data),
        .b_read_i(b_read), .b_address_i(b_addr), .b_waitrequest_o(b_wait),
        .b_readdatavalid_o(b_valid), .b_readdata_o(b_data),
        .s_address_o(s_addr), .s_readdata_i(s_data),
        .verify_done_o(v_done), .id_ok_o(v_ok), .id_fail_o(v_fail)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // vphase counts check cycles done since reset/restart; 3 means arbitrating.
    int          vphase = 0;
    bit          last_a = 1'b0;
    bit          m_av = 1'b0, m_bv = 1'b0;
    logic [31:0] m_ad = 0, m_bd = 0;
    logic [31:0] cap_id = 0, cap_ts = 0;
    bit          m_done = !VER, m_ok = 1'b0, m_fail = 1'b0;

    function automatic logic [31:0] word(input logic addr);
        return addr ? slave_id : slave_ts;
    endfunction

    function automatic void predict(output bit ga, output bit gb, output bit vs, output bit sa);
        bit in_arb;
        in_arb = (!VER || vphase == 3) && !rst;
        vs = VER && in_arb && vstart;
        ga = in_arb && !vs && a_read && (!b_read || !last_a);
        gb = in_arb && !vs && b_read && (!a_read || last_a);
        if (ga)      sa = a_addr;
        else if (gb) sa = b_addr;
        else         sa = (VER && vphase == 0);
    endfunction

    always @(posedge clk) begin
        bit ga, gb, vs, sa;
        predict(ga, gb, vs, sa);
        if (rst) begin
            vphase = 0; last_a = 0; m_av = 0; m_bv = 0; m_ad = 0; m_bd = 0;
            m_done = !VER; m_ok = 0; m_fail = 0;
        end else begin
            m_av = ga;
            m_bv = gb;
            if (ga) begin m_ad = word(a_addr); last_a = 1; end
            if (gb) begin m_bd = word(b_addr); last_a = 0; end
            if (VER) begin
                case (vphase)
                    0: cap_id = slave_id;
                    1: cap_ts = slave_ts;
                    2: begin
                        m_done = 1;
                        m_ok   = (cap_id == EID) && (cap_ts == ETS);
                        m_fail = !m_ok;
                    end
                    default: ;
                endcase
                if (vphase < 3) vphase++;
                else if (vs) begin
                    vphase = 0; m_done = 0; m_ok = 0; m_fail = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit ga, gb, vs, sa;
        if (chk_en) begin
            predict(ga, gb, vs, sa);
            chk("a_waitrequest", a_wait, !ga);
            chk("b_waitrequest", b_wait, !gb);
            chk("s_address", s_addr, sa);
            chk("a_readdatavalid", a_valid, m_av);
            chk("b_readdatavalid", b_valid, m_bv);
            chk("a_readdata", a_data, m_ad);
            chk("b_readdata", b_data, m_bd);
            chk("verify_done", v_done, m_done);
            chk("id_ok", v_ok, m_ok);
            chk("id_fail", v_fail, m_fail);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int na, nb;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_a_wait", a_wait, 1);
        chk("reset_a_valid", a_valid, 0);
        chk("reset_done", v_done, !VER);
        rst = 1'b0;
        a_read = 1'b1; a_addr = 1'b1;

        if (VER) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("lit_done", v_done, 1);
            chk("lit_id_ok", v_ok, 1);
            chk("lit_id_fail", v_fail, 0);
            chk("lit_first_grant", a_wait, 0);
        end else begin
            @(posedge clk);
            @(negedge clk);
            chk("lit_fast_valid", a_valid, 1);
            chk("lit_fast_data", a_data, 32'd1486075654);
            chk("lit_fast_done", v_done, 1);
        end

        // Continuous contention: strict alternation.
        @(posedge clk); #1;
        b_read = 1'b1; b_addr = 1'b0;
        na = 0; nb = 0;
        repeat (6) begin
            @(negedge clk);
            na += a_valid; nb += b_valid;
            chk("lit_one_valid", a_valid ^ b_valid, 1);
        end
        chk("lit_alt_a", na, 3);
        chk("lit_alt_b", nb, 3);
        chk("lit_a_word", a_data, 32'd1486075654);
        chk("lit_b_word", b_data, 32'd0);

        // verify_start with a simultaneous port A request.
        @(posedge clk); #1;
        b_read = 1'b0; vstart = 1'b1;
        @(negedge clk);
        chk("lit_vs_a_wait", a_wait, VER ? 1 : 0);
        @(posedge clk); #1;
        vstart = 1'b0;
        @(negedge clk);
        chk("lit_vs_cleared", v_done, !VER);
        if (VER) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("lit_rerun_ok", v_ok, 1);
            chk("lit_rerun_grant", a_wait, 0);

            @(posedge clk); #1;
            slave_id = 32'h12345678; a_read = 1'b0; vstart = 1'b1;
            @(posedge clk); #1;
            vstart = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("lit_bad_done", v_done, 1);
            chk("lit_bad_ok", v_ok, 0);
            chk("lit_bad_fail", v_fail, 1);
        end

        // Reset right after a B acceptance drops the pending valid.
        @(posedge clk); #1;
        slave_id = EID; a_read = 1'b0; b_read = 1'b1; b_addr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; b_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("lit_rst_b_valid", b_valid, 0);
        chk("lit_rst_b_wait", b_wait, 1);
        chk("lit_rst_a_data", a_data, 0);
        chk("lit_rst_s_addr", s_addr, VER ? 1 : 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            a_read = ($urandom_range(0, 3) != 0);
            b_read = ($urandom_range(0, 3) != 0);
            a_addr = $urandom_range(0, 1);
            b_addr = $urandom_range(0, 1);
            vstart = ($urandom_range(0, 24) == 0);
            if (rst) rst = ($urandom_range(0, 1) == 0);
            else     rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) slave_id = ($urandom_range(0, 1) == 0) ? EID : $urandom;
            if ($urandom_range(0, 39) == 0) slave_ts = ($urandom_range(0, 1) == 0) ? ETS : $urandom;
        end
        @(posedge clk); #1;
        a_read = 0; b_read = 0; vstart = 0; rst = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysid_access_arbiter.md
# sysid_access_arbiter

Sequencer and two-port arbiter in front of the system-ID slave. After reset it reads the ID word (address 1) and the timestamp word (address 0), checks both against expected values, and flags the result. It then shares the slave between two Avalon-MM read requesters: port A (CPU data master) and port B (JTAG/debug master). It replaces direct fabric connection to the sysid slave in niosII_system.

## Interface
- EXPECTED_ID, default 32'd1486075654: expected word at slave address 1.
- EXPECTED_TS, default 32'd0: expected word at slave address 0.
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- verify_start  in  1  one-cycle pulse; re-runs ID/timestamp check.
- a_read, b_read  in  1  read request per port; held until accepted.
- a_address, b_address  in  1  word select (0 = timestamp, 1 = ID).
- a_waitrequest, b_waitrequest  out  1  request not accepted this cycle.
- a_readdatavalid, b_readdatavalid  out  1  readdata valid pulse.
- a_readdata, b_readdata  out  32  registered read data.
- s_address  out  1  address to sysid slave.
- s_readdata  in  32  combinational, zero-latency slave data.
- verify_done  out  1  check has completed since the last reset or restart.
- id_ok  out  1  both words matched.
- id_fail  out  1  at least one word mismatched.

## Operation
- FSM states: V_ID, V_TS, V_CMP, ARB. Reset enters V_ID.
- V_ID: s_address=1, id_q<=s_readdata. Next state V_TS.
- V_TS: s_address=0, ts_q<=s_readdata. Next state V_CMP.
- V_CMP: verify_done<=1. id_ok<=(id_q==EXPECTED_ID && ts_q==EXPECTED_TS). id_fail<=!that match. Next state ARB.
- ARB, no verify_start:
  - A single pending request is granted.
  - If both ports request, the port not granted last wins.
  - The round-robin pointer resets to "last=B", so A wins the first contention.
  - s_address follows the granted port's address; the other port's address is ignored.
  - The non-granted port sees waitrequest=1.
  - With no request, s_address=0.
- verify_start in ARB:
  - It has priority over both ports. No grant is issued that cycle.
  - verify_done, id_ok and id_fail clear to 0 next cycle; the FSM goes to V_ID.
- verify_start is ignored in V_ID, V_TS and V_CMP.
- a_waitrequest and b_waitrequest are 1 in every state except ARB.
- Readdata is held between valid pulses. It changes only on a grant to that port.

## Timing
- Reset values: a/b_waitrequest=1; a/b_readdatavalid=0; a/b_readdata=0; verify_done=0; id_ok=0; id_fail=0; s_address=1 (V_ID); round-robin pointer=B.
- Verification takes 3 cycles after reset deasserts: V_ID, V_TS, V_CMP. verify_done, id_ok and id_fail are valid from the 4th rising edge after reset deasserts, and the FSM is in ARB at that edge.
- Acceptance: x_read && !x_waitrequest on a rising edge.
- Read latency is exactly 1 cycle: x_readdatavalid=1 for one cycle and x_readdata=s_readdata captured at acceptance.
- Throughput is one accepted read per cycle total. A port requesting back-to-back with no contention is accepted every cycle. Under continuous contention grants strictly alternate A, B, A, ...
- Reset mid-operation: all outputs return to reset values on the next edge. A readdatavalid pending from the previous cycle is dropped.

## Configuration
- SYSID_VERIFY_EN defined: behaviour as above.
- SYSID_VERIFY_EN undefined:
  - V_ID, V_TS and V_CMP are not built; reset enters ARB directly.
  - verify_start is ignored.
  - verify_done=1, id_ok=0 and id_fail=0 are constant, including during reset.
  - Arbitration can accept a request on the first edge after reset deasserts.

## Test plan
- Reset, then slave model returns 1486075654 at address 1 and 0 at address 0 → after 3 cycles verify_done=1, id_ok=1, id_fail=0; no waitrequest=0 before ARB.
- Slave returns 0x12345678 at address 1 → verify_done=1, id_ok=0, id_fail=1.
- a_read and b_read asserted continuously, a_address=1, b_address=0 → grants alternate A, B, A, B. A gets 1486075654 and B gets 0, each with a 1-cycle valid pulse.
- verify_start pulsed in ARB with a_read=1 in the same cycle → a_waitrequest=1 that cycle; status clears next cycle; the check re-runs in 3 cycles; A is then granted.
- reset asserted the cycle after a B acceptance → b_readdatavalid=0 next cycle; all outputs at reset values.
- With SYSID_VERIFY_EN undefined, a_read=1, a_address=1 on the first edge after reset → accepted immediately; readdata 1486075654 one cycle later; verify_done=1.
